regfile_seq: RTL and testbench
==============================

Name: regfile_seq

Overview:
- Sequencer for the bit-serial 32x32 register file: runs one register-register operation as a READ phase, then a WRITE phase.
- READ phase: 32 cycles, bit 0 first. Streams rs1/rs2 bits to a bit-serial ALU and captures the ALU's serial result into a 32-bit buffer.
- WRITE phase: 32 cycles. Streams the buffered result into rd through the file's single write path, which shares the port-A address.
- Sits between instruction decode (valid/ready request) and the register file / serial ALU.

Parameters:
- D_WIDTH, 32, register width; also the number of bit-cycles per phase.
- SEL_W, 5, width of register selects and bit position.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  operation request
- req_ready  output  1  high in IDLE only
- req_rs1  input  SEL_W  source A register
- req_rs2  input  SEL_W  source B register
- req_rd  input  SEL_W  destination register
- req_wb  input  1  1 = write result back, 0 = read-only operation
- rf_regA_select  output  SEL_W  to register file port A / write address
- rf_regB_select  output  SEL_W  to register file port B
- rf_bitPos  output  SEL_W  bit position being accessed
- rf_writeEn  output  1  register file write enable
- rf_data_in  output  1  register file write data bit
- rf_portA  input  1  register file port A bit (combinational read)
- rf_portB  input  1  register file port B bit
- alu_opA  output  1  operand A bit (= rf_portA in READ, else 0)
- alu_opB  output  1  operand B bit (= rf_portB in READ, else 0)
- alu_first  output  1  high in READ at bit 0 (ALU carry init)
- alu_last  output  1  high in READ at bit D_WIDTH-1
- alu_res  input  1  ALU result bit, combinational, same cycle
- done  output  1  one-cycle completion pulse
- result  output  D_WIDTH  captured result buffer, valid when done=1

Behaviour:
- Reset values:
  - State IDLE, bit counter 0, latched rs1/rs2/rd/wb = 0, buffer 0.
  - done=0, req_ready=1 after the reset edge.
- rf_writeEn is gated with !rst, so no write happens in a reset cycle even if state is WRITE.
- IDLE:
  - req_ready=1; all rf_* and alu_* outputs 0.
  - On req_valid&req_ready at an edge: latch rs1, rs2, rd, wb; counter=0; go to READ.
- READ:
  - rf_regA_select=rs1, rf_regB_select=rs2, rf_bitPos=counter, rf_writeEn=0.
  - Each edge: buffer <= {alu_res, buffer[D_WIDTH-1:1]} (LSB-first shift-in); counter++.
  - After the edge at counter=D_WIDTH-1: counter wraps to 0. Go to WRITE if wb=1 and rd!=0, otherwise go to IDLE with done=1.
- WRITE:
  - rf_regA_select=rd, rf_regB_select=0, rf_bitPos=counter, rf_writeEn=1, rf_data_in=buffer[0].
  - Each edge: buffer shifts right with rotate (buffer[0] into the MSB), so result is intact at done; counter++.
  - After the edge at counter=D_WIDTH-1: go to IDLE with done=1.
- done:
  - Registered; high exactly one cycle, the first cycle back in IDLE.
  - req_ready is also 1 in that cycle, so a new request may be accepted in it (back-to-back, no bubble).
- Latency, accept edge = cycle 0:
  - READ occupies cycles 1..32; WRITE occupies 33..64; done in cycle 65.
  - With no writeback: done in cycle 33.
- rd==rs1 or rd==rs2 is legal: every read completes before any write, so source values are never corrupted mid-operation.
- rd=0 with wb=1 skips WRITE entirely; x0 stays 0 and no rf_writeEn pulse occurs.
- Reset mid-READ or mid-WRITE:
  - Operation is abandoned.
  - Bits already written to rd stay written; this is a documented partial update and software must re-execute.
  - No done pulse.
- req_valid outside IDLE is ignored; request inputs are only sampled on the accept edge.

Decomposition:
- Shared package:
  - state enum {IDLE, READ, WRITE}
  - constants BIT_LAST = D_WIDTH-1, X0 = 0
- One sub-module, regfile_seq_bitctr: 5-bit counter with clear, enable and wrap flag (last), reused for both phases.
- The FSM, shift buffer and output muxing live in the top.

Test Plan:
- Add, separate rd. Setup: bench serial adder, x1=5, x2=7; req rs1=1, rs2=2, rd=3, wb=1. Required: rf_writeEn high cycles 33..64, done in cycle 65, x3=12, result=12, x1 and x2 unchanged.
- rd=0. Setup: rs1=1, rs2=2, rd=0, wb=1. Required: rf_writeEn never 1, done in cycle 33, x0=0.
- rd==rs1 overwrite. Setup: x1=0xFFFFFFFF, x2=1, add with rs1=1, rs2=2, rd=1. Required: x1=0x00000000, x2=1, alu_first only at bitPos 0, alu_last only at bitPos 31.
- Back-to-back. Setup: req_valid held high with two queued requests. Required: second request accepted in the same cycle done=1 for the first; the two operations are exactly 65 cycles apart.
- Reset mid-WRITE. Setup: assert rst for one cycle while rf_bitPos=10 in WRITE. Required: rf_writeEn=0 in that cycle, no done pulse, state IDLE with req_ready=1 next cycle, rd bits 0..9 updated and bits 10..31 unchanged.
- Read-only. Setup: wb=0, x4=0xA5A5A5A5 as rs1, x0 as rs2, bench ALU passes opA through. Required: result=0xA5A5A5A5 at done in cycle 33, no writes.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the bit-serial register-file sequencer.
package regfile_seq_pkg;

  localparam int D_WIDTH_DEF = 32;
  localparam int SEL_W_DEF   = 5;
  localparam int BIT_LAST    = D_WIDTH_DEF - 1;
  localparam int X0          = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_seq_if.sv
// Request, register-file and serial-ALU signals of the sequencer.
// master = sequencer side, slave = decode / register file / ALU side.
interface regfile_seq_if #(
  parameter int D_WIDTH = 32,
  parameter int SEL_W   = 5
);
  logic               req_valid;
  logic               req_ready;
  logic [SEL_W-1:0]   req_rs1;
  logic [SEL_W-1:0]   req_rs2;
  logic [SEL_W-1:0]   req_rd;
  logic               req_wb;
  logic [SEL_W-1:0]   rf_regA_select;
  logic [SEL_W-1:0]   rf_regB_select;
  logic [SEL_W-1:0]   rf_bitPos;
  logic               rf_writeEn;
  logic               rf_data_in;
  logic               rf_portA;
  logic               rf_portB;
  logic               alu_opA;
  logic               alu_opB;
  logic               alu_first;
  logic               alu_last;
  logic               alu_res;
  logic               done;
  logic [D_WIDTH-1:0] result;

  modport master (
    input  req_valid, req_rs1, req_rs2, req_rd, req_wb, rf_portA, rf_portB, alu_res,
    output req_ready, rf_regA_select, rf_regB_select, rf_bitPos, rf_writeEn, rf_data_in,
           alu_opA, alu_opB, alu_first, alu_last, done, result
  );

  modport slave (
    output req_valid, req_rs1, req_rs2, req_rd, req_wb, rf_portA, rf_portB, alu_res,
    input  req_ready, rf_regA_select, rf_regB_select, rf_bitPos, rf_writeEn, rf_data_in,
           alu_opA, alu_opB, alu_first, alu_last, done, result
  );
endinterface

// File: rtl/regfile_seq_bitctr.sv
// Bit-position counter shared by the READ and WRITE phases; wraps to 0
// after LAST and flags the final bit.
module regfile_seq_bitctr
  import regfile_seq_pkg::*;
#(
  parameter int W    = SEL_W_DEF,
  parameter int LAST = BIT_LAST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == W'(LAST));

  // Count bit positions; explicit wrap keeps non-power-of-two widths correct.
  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= last ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/regfile_seq.sv
// Sequencer for the bit-serial register file: READ phase streams rs1/rs2
// through the serial ALU into a shift buffer, optional WRITE phase streams
// the buffer back into rd over the port-A address.
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  regfile_seq_if.master bus
);

  state_t             state;
  logic [SEL_W-1:0]   rs1Q, rs2Q, rdQ;
  logic               wbQ;
  logic [D_WIDTH-1:0] buffer;
  logic               doneQ;
  logic [SEL_W-1:0]   bitPos;
  logic               bitLast;

  regfile_seq_bitctr #(.W(SEL_W), .LAST(D_WIDTH - 1)) uCtr (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .en   (state != IDLE),
    .cnt  (bitPos),
    .last (bitLast)
  );

  // Phase FSM, operand latches, result shift buffer and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rs1Q   <= '0;
      rs2Q   <= '0;
      rdQ    <= '0;
      wbQ    <= 1'b0;
      buffer <= '0;
      doneQ  <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rs1Q  <= bus.req_rs1;
            rs2Q  <= bus.req_rs2;
            rdQ   <= bus.req_rd;
            wbQ   <= bus.req_wb;
            state <= READ;
          end
        end
        READ: begin
          // LSB-first capture of the ALU result.
          buffer <= {bus.alu_res, buffer[D_WIDTH-1:1]};
          if (bitLast) begin
            // x0 is never written, so a writeback to it skips WRITE.
            if (wbQ && rdQ != SEL_W'(X0)) begin
              state <= WRITE;
            end else begin
              state <= IDLE;
              doneQ <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Rotate so the buffer holds the full result again at done.
          buffer <= {buffer[0], buffer[D_WIDTH-1:1]};
          if (bitLast) begin
            state <= IDLE;
            doneQ <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register-file and ALU output muxing by phase; everything idles at 0.
  always_comb begin
    bus.rf_regA_select = '0;
    bus.rf_regB_select = '0;
    bus.rf_bitPos      = '0;
    bus.rf_writeEn     = 1'b0;
    bus.rf_data_in     = 1'b0;
    bus.alu_opA        = 1'b0;
    bus.alu_opB        = 1'b0;
    bus.alu_first      = 1'b0;
    bus.alu_last       = 1'b0;
    unique case (state)
      READ: begin
        bus.rf_regA_select = rs1Q;
        bus.rf_regB_select = rs2Q;
        bus.rf_bitPos      = bitPos;
        bus.alu_opA        = bus.rf_portA;
        bus.alu_opB        = bus.rf_portB;
        bus.alu_first      = (bitPos == '0);
        bus.alu_last       = bitLast;
      end
      WRITE: begin
        bus.rf_regA_select = rdQ;
        bus.rf_bitPos      = bitPos;
        // No write may land in a reset cycle.
        bus.rf_writeEn     = !rst;
        bus.rf_data_in     = buffer[0];
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.done      = doneQ;
  assign bus.result    = buffer;

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: behavioural register file and serial ALU around the
// DUT, expected values from plain 32-bit arithmetic on a register mirror.
module tb_regfile_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_seq_if #(.D_WIDTH(32), .SEL_W(5)) bus ();

  regfile_seq dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Register file environment with a load port for preloading.
  logic [31:0] regs [32];
  logic [31:0] mdl  [32];
  logic        ldEn;
  logic [4:0]  ldIdx;
  logic [31:0] ldVal;

  assign bus.rf_portA = regs[bus.rf_regA_select][bus.rf_bitPos];
  assign bus.rf_portB = regs[bus.rf_regB_select][bus.rf_bitPos];

  always @(posedge clk) begin
    if (ldEn) regs[ldIdx] <= ldVal;
    else if (bus.rf_writeEn) regs[bus.rf_regA_select][bus.rf_bitPos] <= bus.rf_data_in;
  end

  // Serial ALU: aluMode 0 = add with carry register, 1 = pass opA.
  logic aluMode;
  logic carry;
  logic cin;
  assign cin = bus.alu_first ? 1'b0 : carry;
  assign bus.alu_res = aluMode ? bus.alu_opA : (bus.alu_opA ^ bus.alu_opB ^ cin);
  always @(posedge clk)
    carry <= (bus.alu_opA & bus.alu_opB) | (bus.alu_opA & cin) | (bus.alu_opB & cin);

  task automatic setReg(input int idx, input logic [31:0] val);
    ldIdx = 5'(idx);
    ldVal = val;
    ldEn  = 1'b1;
    @(posedge clk);
    #1 ldEn = 1'b0;
    mdl[idx] = val;
  endtask

  // One operation with per-cycle protocol checks folded into seqBad.
  task automatic run_op(input int rs1, input int rs2, input int rd, input logic wb,
                        output int doneCyc, output int weCnt, output int seqBad,
                        output logic [31:0] res);
    logic wbEff;
    wbEff   = wb && (rd != 0);
    doneCyc = -1;
    weCnt   = 0;
    seqBad  = 0;
    res     = 'x;
    @(posedge clk);
    #1;
    bus.req_rs1 = 5'(rs1);
    bus.req_rs2 = 5'(rs2);
    bus.req_rd  = 5'(rd);
    bus.req_wb  = wb;
    bus.req_valid = 1'b1;
    @(negedge clk);
    if (bus.req_ready !== 1'b1) seqBad++;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        doneCyc = k;
        res = bus.result;
        if (bus.req_ready !== 1'b1 || bus.rf_writeEn !== 1'b0) seqBad++;
        break;
      end
      if (bus.req_ready !== 1'b0) seqBad++;
      if (bus.rf_writeEn === 1'b1) weCnt++;
      if (k <= 32) begin
        if (bus.rf_bitPos !== 5'(k - 1) || bus.rf_regA_select !== 5'(rs1) ||
            bus.rf_regB_select !== 5'(rs2) || bus.rf_writeEn !== 1'b0 ||
            bus.alu_first !== (k == 1) || bus.alu_last !== (k == 32)) seqBad++;
      end else if (k <= 64 && wbEff) begin
        if (bus.rf_bitPos !== 5'(k - 33) || bus.rf_regA_select !== 5'(rd) ||
            bus.rf_regB_select !== 5'd0 || bus.rf_writeEn !== 1'b1 ||
            bus.alu_first !== 1'b0 || bus.alu_last !== 1'b0 || bus.alu_opA !== 1'b0) seqBad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) setReg(i, 32'h0);
    @(negedge clk);
    total++;
    if (bus.rf_writeEn !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.rf_writeEn); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++;
    if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++;
    if ({bus.rf_regA_select, bus.rf_regB_select, bus.rf_bitPos, bus.alu_first, bus.alu_last} !== 17'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {bus.rf_regA_select, bus.rf_regB_select, bus.rf_bitPos, bus.alu_first, bus.alu_last});
    end
  endtask

  task automatic test_add();
    int dc, we, sb;
    logic [31:0] res;
    aluMode = 1'b0;
    setReg(1, 32'd5);
    setReg(2, 32'd7);
    setReg(3, $urandom);
    run_op(1, 2, 3, 1'b1, dc, we, sb, res);
    total++; if (dc != 65) begin bad++; $display("FAIL add_done_cycle got=%0d want=65", dc); end
    total++; if (we != 32) begin bad++; $display("FAIL add_we_count got=%0d want=32", we); end
    total++; if (sb != 0) begin bad++; $display("FAIL add_sequence got=%0d errs want=0", sb); end
    total++; if (regs[3] !== 32'd12) begin bad++; $display("FAIL add_x3 got=%h want=%h", regs[3], 32'd12); end
    total++; if (res !== 32'd12) begin bad++; $display("FAIL add_result got=%h want=%h", res, 32'd12); end
    total++; if (regs[1] !== 32'd5 || regs[2] !== 32'd7) begin
      bad++; $display("FAIL add_sources got=%h,%h want=5,7", regs[1], regs[2]); end
  endtask

  task automatic test_rd0();
    int dc, we, sb;
    logic [31:0] res;
    aluMode = 1'b0;
    run_op(1, 2, 0, 1'b1, dc, we, sb, res);
    total++; if (dc != 33) begin bad++; $display("FAIL rd0_done_cycle got=%0d want=33", dc); end
    total++; if (we != 0) begin bad++; $display("FAIL rd0_we_count got=%0d want=0", we); end
    total++; if (regs[0] !== 32'h0) begin bad++; $display("FAIL rd0_x0 got=%h want=0", regs[0]); end
    total++; if (res !== 32'd12 || sb != 0) begin
      bad++; $display("FAIL rd0_result got=%h errs=%0d want=%h errs=0", res, sb, 32'd12); end
  endtask

  task automatic test_overwrite();
    int dc, we, sb;
    logic [31:0] res;
    aluMode = 1'b0;
    setReg(1, 32'hFFFF_FFFF);
    setReg(2, 32'h1);
    run_op(1, 2, 1, 1'b1, dc, we, sb, res);
    total++; if (regs[1] !== 32'h0) begin bad++; $display("FAIL ovw_x1 got=%h want=0", regs[1]); end
    total++; if (regs[2] !== 32'h1) begin bad++; $display("FAIL ovw_x2 got=%h want=1", regs[2]); end
    total++; if (sb != 0 || dc != 65) begin
      bad++; $display("FAIL ovw_sequence got=%0d errs done=%0d want=0 errs done=65", sb, dc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int d1, d2;
    logic acc;
    a = $urandom; b = $urandom;
    aluMode = 1'b0;
    setReg(1, a);
    setReg(2, b);
    d1 = -1; d2 = -1; acc = 1'b0;
    @(posedge clk);
    #1;
    bus.req_rs1 = 5'd1; bus.req_rs2 = 5'd2; bus.req_rd = 5'd5; bus.req_wb = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_rs1 = 5'd5; bus.req_rs2 = 5'd1; bus.req_rd = 5'd6; bus.req_wb = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 && d1 < 0) begin
        d1 = k;
        acc = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
      end else if (bus.done === 1'b1) begin
        d2 = k;
        break;
      end
    end
    bus.req_valid = 1'b0;
    total++; if (d1 != 65 || acc !== 1'b1) begin
      bad++; $display("FAIL b2b_first done=%0d accept=%b want done=65 accept=1", d1, acc); end
    total++; if (d2 - d1 != 65) begin bad++; $display("FAIL b2b_spacing got=%0d want=65", d2 - d1); end
    total++; if (regs[5] !== a + b) begin bad++; $display("FAIL b2b_x5 got=%h want=%h", regs[5], a + b); end
    total++; if (regs[6] !== a + b + a) begin bad++; $display("FAIL b2b_x6 got=%h want=%h", regs[6], a + b + a); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a, b, old, sum, exp;
    logic seen;
    int doneSeen;
    a = $urandom; b = $urandom; old = $urandom;
    sum = a + b;
    exp = {old[31:10], sum[9:0]};
    seen = 1'b0; doneSeen = 0;
    aluMode = 1'b0;
    setReg(1, a);
    setReg(2, b);
    setReg(7, old);
    @(posedge clk);
    #1;
    bus.req_rs1 = 5'd1; bus.req_rs2 = 5'd2; bus.req_rd = 5'd7; bus.req_wb = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 43; k++) @(negedge clk);
    seen = (bus.rf_writeEn === 1'b1) && (bus.rf_bitPos === 5'd10);
    total++; if (!seen) begin bad++; $display("FAIL rmw_position we=%b pos=%0d want we=1 pos=10", bus.rf_writeEn, bus.rf_bitPos); end
    rst = 1'b1;
    #1;
    total++; if (bus.rf_writeEn !== 1'b0) begin bad++; $display("FAIL rmw_we_gated got=%b want=0", bus.rf_writeEn); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rmw_idle_ready got=%b want=1", bus.req_ready); end
    if (bus.done === 1'b1) doneSeen++;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
    end
    total++; if (doneSeen != 0) begin bad++; $display("FAIL rmw_no_done got=%0d pulses want=0", doneSeen); end
    total++; if (regs[7] !== exp) begin bad++; $display("FAIL rmw_partial got=%h want=%h", regs[7], exp); end
    mdl[7] = exp;
  endtask

  task automatic test_readonly();
    int dc, we, sb;
    logic [31:0] res, keep;
    keep = $urandom;
    setReg(4, 32'hA5A5_A5A5);
    setReg(9, keep);
    aluMode = 1'b1;
    run_op(4, 0, 9, 1'b0, dc, we, sb, res);
    aluMode = 1'b0;
    total++; if (res !== 32'hA5A5_A5A5) begin bad++; $display("FAIL ro_result got=%h want=a5a5a5a5", res); end
    total++; if (dc != 33) begin bad++; $display("FAIL ro_done_cycle got=%0d want=33", dc); end
    total++; if (we != 0 || regs[9] !== keep) begin
      bad++; $display("FAIL ro_no_write we=%0d x9=%h want we=0 x9=%h", we, regs[9], keep); end
  endtask

  task automatic test_random();
    int dc, we, sb, rs1, rs2, rd, wantDc;
    logic wb;
    logic [31:0] res, sum;
    int mism;
    aluMode = 1'b0;
    for (int i = 1; i < 32; i++) setReg(i, $urandom);
    mdl[0] = 32'h0;
    for (int n = 0; n < 10; n++) begin
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      rd  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom_range(0, 31);
      wb  = ($urandom_range(0, 3) != 0);
      sum = mdl[rs1] + mdl[rs2];
      wantDc = (wb && rd != 0) ? 65 : 33;
      run_op(rs1, rs2, rd, wb, dc, we, sb, res);
      if (wb && rd != 0) mdl[rd] = sum;
      total++; if (res !== sum || dc != wantDc || sb != 0) begin
        bad++; $display("FAIL rand_op%0d res=%h done=%0d errs=%0d want res=%h done=%0d errs=0",
                        n, res, dc, sb, sum, wantDc); end
    end
    mism = 0;
    for (int i = 0; i < 32; i++) if (regs[i] !== mdl[i]) mism++;
    total++; if (mism != 0) begin bad++; $display("FAIL rand_regfile got=%0d mismatching regs want=0", mism); end
  endtask

  initial begin
    rst = 1'b1;
    ldEn = 1'b0; ldIdx = '0; ldVal = '0;
    aluMode = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd = '0; bus.req_wb = 1'b0;
    test_reset();
    test_add();
    test_rd0();
    test_overwrite();
    test_back_to_back();
    test_reset_mid_write();
    test_readonly();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
